gs_update: RTL and testbench

GS_UPDATE -- requirements
Module: gs_update

---
 rtl/gs_update.sv | 159 +++++++++++++++
 tb/tb_gs_update.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gs_update.sv
// Gauss-Seidel row update: x_i = (b_i - sum a_ij*x_j) * (1/a_ii), Q16.16 result saturated to 32 bits.
// Latency: o_valid 33 cycles after the later of last-term capture and reciprocal capture.
// Backpressure: none; inputs are accepted only in the states that use them, all others are dropped.
module gs_update #(
    parameter int ACC_W = 48
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_b_valid,
    input  logic [15:0] i_b,
    input  logic        i_term_valid,
    input  logic [7:0]  i_coef,
    input  logic [31:0] i_x,
    input  logic        i_term_last,
    input  logic        i_recip_valid,
    input  logic [31:0] i_recip,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_x_new,
    output logic        o_ovf
);

    localparam int PROD_W = ACC_W + 32;
    localparam int RES_W  = PROD_W - 24;

    typedef enum logic [1:0] {IDLE, ACC, MUL, DONE} state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [31:0]         recip_q, recip_d;       // latched reciprocal, shifted right during MUL
    logic                recip_have_q, recip_have_d;
    logic                terms_done_q, terms_done_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [PROD_W-1:0]   mcand_q, mcand_d;       // sign-extended acc, shifted left during MUL
    logic [4:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [31:0]         x_new_q, x_new_d;
    logic                ovf_q, ovf_d;

    logic signed [39:0]  term_prod;
    logic [RES_W-1:0]    res;

    assign term_prod = $signed(i_coef) * $signed(i_x);

    // Next-state logic: row accumulation, reciprocal capture, serial multiply, saturation.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        recip_d      = recip_q;
        recip_have_d = recip_have_q;
        terms_done_d = terms_done_q;
        prod_d       = prod_q;
        mcand_d      = mcand_q;
        cnt_d        = cnt_q;
        valid_d      = 1'b0;
        x_new_d      = x_new_q;
        ovf_d        = ovf_q;
        res          = prod_q[PROD_W-1:24];

        case (state_q)
            IDLE: begin
                // A term arriving together with b is dropped on purpose.
                if (i_b_valid) begin
                    acc_d        = {{(ACC_W-32){i_b[15]}}, i_b, 16'h0000};
                    recip_have_d = 1'b0;
                    terms_done_d = 1'b0;
                    state_d      = ACC;
                end
            end
            ACC: begin
                if (i_term_valid && !terms_done_q) begin
                    acc_d = acc_q - {{(ACC_W-40){term_prod[39]}}, term_prod};
                    if (i_term_last) begin
                        terms_done_d = 1'b1;
                    end
                end
                if (i_recip_valid && !recip_have_q) begin
                    recip_d      = i_recip;
                    recip_have_d = 1'b1;
                end
                // Uses registered flags, so a same-cycle capture moves to MUL one edge later.
                if (terms_done_q && recip_have_q) begin
                    state_d = MUL;
                    prod_d  = '0;
                    mcand_d = {{(PROD_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
                    cnt_d   = 5'd0;
                end
            end
            MUL: begin
                prod_d  = prod_q + (recip_q[0] ? mcand_q : '0);
                mcand_d = mcand_q << 1;
                recip_d = recip_q >> 1;
                cnt_d   = cnt_q + 5'd1;
                res     = prod_d[PROD_W-1:24];
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    // In range only when every bit from 31 upward matches the sign.
                    if (!res[RES_W-1] && (|res[RES_W-1:31])) begin
                        x_new_d = 32'h7FFF_FFFF;
                        ovf_d   = 1'b1;
                    end else if (res[RES_W-1] && !(&res[RES_W-1:31])) begin
                        x_new_d = 32'h8000_0000;
                        ovf_d   = 1'b1;
                    end else begin
                        x_new_d = res[31:0];
                        ovf_d   = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; synchronous reset discards any in-flight row.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            recip_q      <= '0;
            recip_have_q <= 1'b0;
            terms_done_q <= 1'b0;
            prod_q       <= '0;
            mcand_q      <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            x_new_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            recip_q      <= recip_d;
            recip_have_q <= recip_have_d;
            terms_done_q <= terms_done_d;
            prod_q       <= prod_d;
            mcand_q      <= mcand_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            x_new_q      <= x_new_d;
            ovf_q        <= ovf_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o_x_new = x_new_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_gs_update.sv
// Randomized and directed bench for gs_update against a plain-arithmetic row model.
// Latency: checks o_valid arrives exactly 33 edges after the later capture edge.
// Backpressure: none; injects stray inputs in states where they must be ignored.
module tb_gs_update;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_b_valid = 1'b0;
    logic [15:0] i_b = '0;
    logic        i_term_valid = 1'b0;
    logic [7:0]  i_coef = '0;
    logic [31:0] i_x = '0;
    logic        i_term_last = 1'b0;
    logic        i_recip_valid = 1'b0;
    logic [31:0] i_recip = '0;
    logic        o_busy, o_valid, o_ovf;
    logic [31:0] o_x_new;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic signed [7:0]  coef_a [16];
    logic signed [31:0] x_a    [16];
    int                 gap_a  [16];

    gs_update #(.ACC_W(48)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_b_valid(i_b_valid), .i_b(i_b),
        .i_term_valid(i_term_valid), .i_coef(i_coef), .i_x(i_x), .i_term_last(i_term_last),
        .i_recip_valid(i_recip_valid), .i_recip(i_recip),
        .o_busy(o_busy), .o_valid(o_valid), .o_x_new(o_x_new), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_b_valid = 1'b0; i_term_valid = 1'b0; i_term_last = 1'b0; i_recip_valid = 1'b0;
    endtask

    // Runs one row; terms come from coef_a/x_a/gap_a. abort_at>0 pulses reset that many
    // edges after the later capture edge and expects the row to vanish.
    task automatic run_row(input logic signed [15:0] b, input int nterms, input int recip_slot,
                           input logic [31:0] recip, input bit noise, input int abort_at,
                           input string tag, output logic [31:0] got_x, output logic got_ovf);
        logic signed [47:0] accm;
        logic signed [79:0] p;
        logic signed [55:0] r;
        longint             rl, prod;
        logic [31:0]        exp_x;
        logic               exp_ovf;
        int                 slot_of [16];
        int                 last_slot, end_slot, t, e_term, e_recip, e_ref;
        bit                 got, any_valid;

        got_x = '0; got_ovf = 1'b0;
        // Reference: exact rational-free arithmetic on wide integers.
        accm = {{16{b[15]}}, b, 16'h0000};
        for (int k = 0; k < nterms; k++) begin
            prod = longint'(coef_a[k]) * longint'(x_a[k]);
            accm = accm - prod[47:0];
            slot_of[k] = (k == 0) ? gap_a[0] : slot_of[k-1] + 1 + gap_a[k];
        end
        p  = $signed({{32{accm[47]}}, accm}) * $signed({48'b0, recip});
        r  = p[79:24];
        rl = longint'(r);
        if (rl > 64'sh7FFF_FFFF) begin
            exp_x = 32'h7FFF_FFFF; exp_ovf = 1'b1;
        end else if (rl < -64'sh8000_0000) begin
            exp_x = 32'h8000_0000; exp_ovf = 1'b1;
        end else begin
            exp_x = rl[31:0]; exp_ovf = 1'b0;
        end

        last_slot = slot_of[nterms-1];
        end_slot  = ((last_slot > recip_slot) ? last_slot : recip_slot) + (noise ? 2 : 0);

        i_b_valid = 1'b1; i_b = b;
        if (noise) begin
            i_term_valid = 1'b1; i_coef = 8'($urandom); i_x = $urandom; i_term_last = 1'b1;
        end
        tick();
        clear_inputs();
        chk({tag, "_busy_acc"}, o_busy, 1);

        t = 0; e_term = 0; e_recip = 0;
        for (int s = 0; s <= end_slot; s++) begin
            clear_inputs();
            if (t < nterms && slot_of[t] == s) begin
                i_term_valid = 1'b1; i_coef = coef_a[t]; i_x = x_a[t];
                i_term_last = (t == nterms - 1);
                t++;
            end else if (noise && t == nterms) begin
                i_term_valid = 1'b1; i_coef = 8'($urandom); i_x = $urandom;
                i_term_last = 1'($urandom);
            end
            if (s == recip_slot) begin
                i_recip_valid = 1'b1; i_recip = recip;
            end else if (noise && s > recip_slot) begin
                i_recip_valid = 1'b1; i_recip = $urandom;
            end
            if (noise && s > 0) begin
                i_b_valid = 1'b1; i_b = 16'($urandom);
            end
            tick();
            if (t == nterms && e_term == 0) e_term = cyc;
            if (s == recip_slot) e_recip = cyc;
        end
        clear_inputs();
        e_ref = (e_term > e_recip) ? e_term : e_recip;

        got = 1'b0; any_valid = 1'b0;
        for (int k = cyc - e_ref; k < 60 && !got; k++) begin
            if (abort_at > 0 && k == abort_at) begin
                i_reset = 1'b1;
                tick();
                i_reset = 1'b0;
                chk({tag, "_abort_busy"}, o_busy, 0);
                chk({tag, "_abort_valid"}, o_valid, 0);
                chk({tag, "_abort_x"}, o_x_new, 0);
                for (int j = 0; j < 40; j++) begin
                    tick();
                    if (o_valid) any_valid = 1'b1;
                end
                chk({tag, "_abort_no_valid"}, any_valid, 0);
                return;
            end
            if (noise && k < 3) begin
                i_b_valid = 1'b1; i_b = 16'($urandom);
            end
            tick();
            clear_inputs();
            if (o_valid) begin
                got = 1'b1;
                chk({tag, "_latency"}, cyc - e_ref, 33);
                chk({tag, "_x"}, o_x_new, exp_x);
                chk({tag, "_ovf"}, o_ovf, exp_ovf);
                got_x = o_x_new; got_ovf = o_ovf;
            end else if (k == 20) begin
                chk({tag, "_busy_mul"}, o_busy, 1);
            end
        end
        chk({tag, "_seen_valid"}, got, 1);
        tick();
        chk({tag, "_valid_pulse"}, o_valid, 0);
        chk({tag, "_idle"}, o_busy, 0);
        chk({tag, "_x_hold"}, o_x_new, got_x);
    endtask

    task automatic set_one(input logic signed [7:0] c, input logic signed [31:0] x, input int gap);
        coef_a[0] = c; x_a[0] = x; gap_a[0] = gap;
    endtask

    initial begin
        logic [31:0] gx;
        logic        go;
        int          nt;

        clear_inputs();
        i_reset = 1'b1;
        tick(); tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_x", o_x_new, 0);
        chk("rst_ovf", o_ovf, 0);
        i_reset = 1'b0;
        tick();

        set_one(8'sd2, 32'sh0001_0000, 0);
        run_row(16'sd10, 1, 0, 32'h0040_0000, 1'b0, 0, "same_cyc", gx, go);
        chk("same_cyc_const", {go, gx}, {1'b0, 32'h0002_0000});
        run_row(16'sd10, 1, 2, 32'h0040_0000, 1'b0, 0, "recip_late", gx, go);
        chk("recip_late_const", {go, gx}, {1'b0, 32'h0002_0000});
        set_one(8'sd2, 32'sh0001_0000, 2);
        run_row(16'sd10, 1, 0, 32'h0040_0000, 1'b0, 0, "recip_early", gx, go);
        chk("recip_early_const", {go, gx}, {1'b0, 32'h0002_0000});
        set_one(8'sd1, 32'sh0001_0000, 0);
        run_row(-16'sd3, 1, 0, 32'h0080_0000, 1'b0, 0, "neg", gx, go);
        chk("neg_const", {go, gx}, {1'b0, 32'hFFFE_0000});
        set_one(8'sd0, 32'sh0, 0);
        run_row(16'sd1, 1, 0, 32'h0055_5555, 1'b0, 0, "trunc", gx, go);
        chk("trunc_const", {go, gx}, {1'b0, 32'h0000_5555});
        set_one(-8'sd128, 32'sh7FFF_FFFF, 0);
        run_row(16'sd32767, 1, 0, 32'h0100_0000, 1'b0, 0, "sat", gx, go);
        chk("sat_const", {go, gx}, {1'b1, 32'h7FFF_FFFF});

        set_one(8'sd2, 32'sh0001_0000, 0);
        run_row(16'sd10, 1, 0, 32'h0040_0000, 1'b0, 10, "abort", gx, go);
        run_row(16'sd10, 1, 0, 32'h0040_0000, 1'b0, 0, "after_abort", gx, go);
        chk("after_abort_const", {go, gx}, {1'b0, 32'h0002_0000});

        for (int n = 0; n < 40; n++) begin
            nt = $urandom_range(1, 6);
            for (int k = 0; k < nt; k++) begin
                coef_a[k] = 8'($urandom);
                if ($urandom_range(0, 1) == 0)
                    x_a[k] = $signed($urandom) >>> $urandom_range(8, 20);
                else
                    x_a[k] = $urandom;
                gap_a[k] = $urandom_range(0, 2);
            end
            run_row(16'($urandom), nt, $urandom_range(0, 3 * nt + 4),
                    ($urandom_range(0, 1) == 0) ? ($urandom >> $urandom_range(4, 12)) : $urandom,
                    1'($urandom), 0, $sformatf("rnd%0d", n), gx, go);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
